// File: rtl/core_ctrl_defs.sv
// ============================================================================
// core_ctrl_defs : opcodes, FSM state encoding and datapath select codes
// Revision       : 1.0
// ============================================================================
`default_nettype none

package core_ctrl_defs;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_BRANCH = 3'd6,
      ST_TRAP   = 3'd7
   } state_t;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   typedef enum logic [2:0] {
      CLS_LOAD    = 3'd0,
      CLS_STORE   = 3'd1,
      CLS_IMM     = 3'd2,
      CLS_REG     = 3'd3,
      CLS_BRANCH  = 3'd4,
      CLS_ILLEGAL = 3'd5
   } instr_class_t;

   function automatic instr_class_t classify(input logic [6:0] opcode);
      instr_class_t cls;
      case (opcode)
         OP_LOAD:   cls = CLS_LOAD;
         OP_STORE:  cls = CLS_STORE;
         OP_IMM:    cls = CLS_IMM;
         OP_REG:    cls = CLS_REG;
         OP_BRANCH: cls = CLS_BRANCH;
         default:   cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_timeout_cnt.sv
// ============================================================================
// mem_timeout_cnt : counts unanswered memory-request cycles, flags expiry
// Revision        : 1.0
// ============================================================================
`default_nettype none

module mem_timeout_cnt #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic active,
   input  logic clear,
   output logic expired
);

   localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

   logic [15:0] r_count;

   // Expiry is combinational so the FSM can divert to TRAP in the same cycle.
   assign expired = active && (r_count == LIMIT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (active && (r_count != LIMIT)) begin
         r_count <= r_count + 16'd1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control : multicycle control FSM for the RV32I-subset core
// Revision           : 1.0
// ============================================================================
`default_nettype none

module multicycle_control
   import core_ctrl_defs::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instrucao,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             reg_write,
   output logic             wb_sel,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] instret
);

   state_t           r_state;
   state_t           w_next;
   logic [1:0]       r_trap_cause;
   logic [1:0]       w_cause;
   logic [CNT_W-1:0] r_instret;
   logic             w_retire;
   logic             w_wait;
   logic             w_expired;
   instr_class_t     w_class;
   logic             w_unused_ir;

   assign w_class     = classify(instrucao[6:0]);
   assign w_unused_ir = ^instrucao[31:7];

   assign w_wait = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !mem_ready;

   mem_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .active  (w_wait),
      .clear   (w_next != r_state),
      .expired (w_expired)
   );

   always_comb begin
      w_next   = r_state;
      w_cause  = r_trap_cause;
      w_retire = 1'b0;
      case (r_state)
         ST_IDLE: w_next = ST_FETCH;
         ST_FETCH: begin
            if (mem_ready) begin
               w_next = ST_DECODE;
            end else if (w_expired) begin
               w_next  = ST_TRAP;
               w_cause = CAUSE_TIMEOUT;
            end
         end
         ST_DECODE: begin
            case (w_class)
               CLS_LOAD, CLS_STORE, CLS_IMM, CLS_REG: w_next = ST_EXEC;
               CLS_BRANCH: w_next = ST_BRANCH;
               default: begin
                  w_next  = ST_TRAP;
                  w_cause = CAUSE_ILLEGAL;
               end
            endcase
         end
         ST_EXEC: begin
            // IR is stable after DECODE, so only dispatched classes arrive here.
            case (w_class)
               CLS_LOAD, CLS_STORE: w_next = ST_MEM;
               CLS_IMM, CLS_REG:    w_next = ST_WB;
               default: begin
                  w_next  = ST_TRAP;
                  w_cause = CAUSE_ILLEGAL;
               end
            endcase
         end
         ST_MEM: begin
            if (mem_ready) begin
               if (w_class == CLS_STORE) begin
                  w_next   = ST_FETCH;
                  w_retire = 1'b1;
               end else begin
                  w_next = ST_WB;
               end
            end else if (w_expired) begin
               w_next  = ST_TRAP;
               w_cause = CAUSE_TIMEOUT;
            end
         end
         ST_WB: begin
            w_next   = ST_FETCH;
            w_retire = 1'b1;
         end
         ST_BRANCH: begin
            w_next   = ST_FETCH;
            w_retire = 1'b1;
         end
         ST_TRAP: w_next = ST_TRAP;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_trap_cause <= CAUSE_NONE;
         r_instret    <= '0;
      end else begin
         r_state      <= w_next;
         r_trap_cause <= w_cause;
         if (w_retire) begin
            r_instret <= r_instret + CNT_W'(1);
         end
      end
   end

   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 1'b0;
      alu_src_a = 1'b0;
      alu_src_b = SRCB_RS2;
      alu_op    = ALU_ADD;
      reg_write = 1'b0;
      wb_sel    = 1'b0;
      case (r_state)
         ST_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         ST_DECODE: alu_src_b = SRCB_IMM;
         ST_EXEC: begin
            alu_src_a = 1'b1;
            case (w_class)
               CLS_LOAD, CLS_STORE: begin
                  alu_src_b = SRCB_IMM;
                  alu_op    = ALU_ADD;
               end
               CLS_IMM: begin
                  alu_src_b = SRCB_IMM;
                  alu_op    = ALU_FUNCT;
               end
               CLS_REG: begin
                  alu_src_b = SRCB_RS2;
                  alu_op    = ALU_FUNCT;
               end
               default: ;
            endcase
         end
         ST_MEM: begin
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            mem_we   = (w_class == CLS_STORE);
         end
         ST_WB: begin
            reg_write = 1'b1;
            wb_sel    = (w_class == CLS_LOAD);
         end
         ST_BRANCH: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_RS2;
            alu_op    = ALU_SUB;
            pc_write  = zero;
            pc_src    = 1'b1;
         end
         default: ;
      endcase
   end

   assign trap       = (r_state == ST_TRAP);
   assign trap_cause = r_trap_cause;
   assign instret    = r_instret;

endmodule

`default_nettype wire
